// File: rtl/pea_pkg.sv
// Processing-element-array shared parameters.
package pea_pkg;

    localparam int unsigned N_BITS = 32;

endpackage

// File: rtl/stream_intf_pkg.sv
// Input-stream interface parameters shared by the stream buffers.
package stream_intf_pkg;

    localparam int unsigned N_DMA_CH_PER_IN_STREAM = 4;
    localparam int unsigned TRANS_W                = 16;
    localparam int unsigned IN_FIFO_DEPTH          = 4;

endpackage

// File: rtl/dma_in_ch_fifo.sv
// Single-channel FIFO: push/pop/flush, registered head, full/empty from occupancy.
module dma_in_ch_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic             flush_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             full_o,
    output logic             empty_o,
    output logic [WIDTH-1:0] head_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic             w_push;
    logic             w_pop;

    assign full_o  = (r_count == (AW+1)'(DEPTH));
    assign empty_o = (r_count == '0);
    assign w_push  = push_i && !full_o && !flush_i;
    assign w_pop   = pop_i && !empty_o && !flush_i;
    // Head is a register read; zero when empty so reset/flush shows 0.
    assign head_o  = empty_o ? '0 : r_mem[r_rd_ptr];

    // Pointer and occupancy bookkeeping; flush empties the FIFO.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage array; contents are don't-care while the slot is unoccupied.
    always_ff @(posedge clk_i) begin
        if (w_push) r_mem[r_wr_ptr] <= data_i;
    end

endmodule

// File: rtl/dma_in_stream_buffer.sv
// Per-channel buffering between DMA channels and the PEA crossbar for one transfer.
module dma_in_stream_buffer
    import stream_intf_pkg::*;
    import pea_pkg::*;
#(
    parameter int unsigned N_CH  = N_DMA_CH_PER_IN_STREAM,
    parameter int unsigned DEPTH = IN_FIFO_DEPTH
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   start_i,
    input  logic                   clear_i,
    input  logic [TRANS_W-1:0]     trans_size_i,
    input  logic [N_CH-1:0]        dma_valid_i,
    input  logic [N_CH*N_BITS-1:0] dma_data_i,
    output logic [N_CH-1:0]        dma_ready_o,
    input  logic [N_CH-1:0]        consume_i,
    output logic [N_CH-1:0]        ch_valid_o,
    output logic [N_CH*N_BITS-1:0] ch_data_o,
    output logic                   busy_o,
    output logic                   done_o
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_t;

    state_t             r_state;
    logic               r_done;
    logic [TRANS_W-1:0] r_in_rem  [N_CH];
    logic [TRANS_W-1:0] r_out_rem [N_CH];
    logic [N_CH-1:0]    w_full;
    logic [N_CH-1:0]    w_empty;
    logic [N_CH-1:0]    w_push;
    logic [N_CH-1:0]    w_pop;
    logic               w_all_out_done;

    assign busy_o = (r_state == ST_RUN);
    assign done_o = r_done;

    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        assign dma_ready_o[c] = (r_state == ST_RUN) && !w_full[c] && (r_in_rem[c] != '0);
        assign w_push[c]      = dma_valid_i[c] && dma_ready_o[c];
        assign ch_valid_o[c]  = !w_empty[c];
        assign w_pop[c]       = consume_i[c] && ch_valid_o[c] && (r_state == ST_RUN);

        dma_in_ch_fifo #(
            .DEPTH (DEPTH),
            .WIDTH (N_BITS)
        ) u_fifo (
            .clk_i   (clk_i),
            .rst_i   (rst_i),
            .push_i  (w_push[c]),
            .pop_i   (w_pop[c]),
            .flush_i (clear_i),
            .data_i  (dma_data_i[c*N_BITS +: N_BITS]),
            .full_o  (w_full[c]),
            .empty_o (w_empty[c]),
            .head_o  (ch_data_o[c*N_BITS +: N_BITS])
        );
    end

    // Transfer completes when every channel's remaining-output count reaches zero this cycle.
    always_comb begin
        w_all_out_done = 1'b1;
        for (int c = 0; c < N_CH; c++) begin
            if (r_out_rem[c] != TRANS_W'(w_pop[c])) w_all_out_done = 1'b0;
        end
    end

    // Transfer FSM with per-channel input/output word counters.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
            r_done  <= 1'b0;
            for (int c = 0; c < N_CH; c++) begin
                r_in_rem[c]  <= '0;
                r_out_rem[c] <= '0;
            end
        end else if (clear_i) begin
            r_state <= ST_IDLE;
            r_done  <= 1'b0;
            for (int c = 0; c < N_CH; c++) begin
                r_in_rem[c]  <= '0;
                r_out_rem[c] <= '0;
            end
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start_i) begin
                        if (trans_size_i != '0) begin
                            r_state <= ST_RUN;
                            for (int c = 0; c < N_CH; c++) begin
                                r_in_rem[c]  <= trans_size_i;
                                r_out_rem[c] <= trans_size_i;
                            end
                        end else begin
                            r_state <= ST_DONE;
                            r_done  <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    for (int c = 0; c < N_CH; c++) begin
                        if (w_push[c]) r_in_rem[c]  <= r_in_rem[c]  - TRANS_W'(1);
                        if (w_pop[c])  r_out_rem[c] <= r_out_rem[c] - TRANS_W'(1);
                    end
                    if (w_all_out_done) begin
                        r_state <= ST_DONE;
                        r_done  <= 1'b1;
                    end
                end
                ST_DONE: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dma_in_stream_buffer.sv
// Scoreboard bench for dma_in_stream_buffer: per-channel expected-word queues plus scenario tasks.
module tb_dma_in_stream_buffer;
    import stream_intf_pkg::*;
    import pea_pkg::*;

    localparam int unsigned NC = 4;
    localparam int unsigned DP = 4;
    localparam int unsigned W  = N_BITS;

    logic               clk = 1'b0;
    logic               rst;
    logic               start;
    logic               clear;
    logic [TRANS_W-1:0] tsize;
    logic [NC-1:0]      dvalid;
    logic [NC*W-1:0]    ddata;
    logic [NC-1:0]      dready;
    logic [NC-1:0]      consume;
    logic [NC-1:0]      cvalid;
    logic [NC*W-1:0]    cdata;
    logic               busy;
    logic               done;

    int n_checks = 0;
    int n_pass   = 0;
    int n_pop [NC];
    int n_done   = 0;

    logic [W-1:0] sb_q [NC][$];
    logic [W-1:0] m_head;
    logic         m_exp_v;

    dma_in_stream_buffer #(
        .N_CH  (NC),
        .DEPTH (DP)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .start_i      (start),
        .clear_i      (clear),
        .trans_size_i (tsize),
        .dma_valid_i  (dvalid),
        .dma_data_i   (ddata),
        .dma_ready_o  (dready),
        .consume_i    (consume),
        .ch_valid_o   (cvalid),
        .ch_data_o    (cdata),
        .busy_o       (busy),
        .done_o       (done)
    );

    always #5 clk = ~clk;

    // Advance to just after the next rising edge and present fresh DMA data.
    task automatic step();
        @(posedge clk);
        #1;
        for (int c = 0; c < NC; c++) ddata[c*W +: W] = W'($urandom());
    endtask

    task automatic do_start(input int size);
        start = 1'b1;
        tsize = TRANS_W'(size);
        step();
        start = 1'b0;
    endtask

    // Run until done_o is seen at a falling edge or the budget expires.
    task automatic wait_done(input int budget);
        int cyc;
        cyc = 0;
        @(negedge clk);
        while (done !== 1'b1 && cyc < budget) begin
            step();
            @(negedge clk);
            cyc++;
        end
    endtask

    // Scoreboard: accepted DMA words queue up; every visible head must match the queue front.
    task automatic sb_monitor();
        forever begin
            @(negedge clk);
            if (done === 1'b1) n_done++;
            for (int c = 0; c < NC; c++) begin
                if (rst) begin
                    n_checks++;
                    if (cvalid[c] !== 1'b0) $display("FAIL rst_valid ch%0d got %b expected 0", c, cvalid[c]);
                    else n_pass++;
                    sb_q[c].delete();
                end else begin
                    m_exp_v = (sb_q[c].size() != 0);
                    n_checks++;
                    if (cvalid[c] !== m_exp_v) $display("FAIL sb_valid ch%0d got %b expected %b", c, cvalid[c], m_exp_v);
                    else n_pass++;
                    if (m_exp_v) begin
                        m_head = cdata[c*W +: W];
                        n_checks++;
                        if (m_head !== sb_q[c][0]) $display("FAIL sb_data ch%0d got %h expected %h", c, m_head, sb_q[c][0]);
                        else n_pass++;
                    end
                    if (sb_q[c].size() == DP) begin
                        n_checks++;
                        if (dready[c] !== 1'b0) $display("FAIL full_ready ch%0d got %b expected 0", c, dready[c]);
                        else n_pass++;
                    end
                    if (clear) begin
                        sb_q[c].delete();
                    end else begin
                        if (consume[c] && cvalid[c] === 1'b1 && sb_q[c].size() != 0) begin
                            void'(sb_q[c].pop_front());
                            n_pop[c]++;
                        end
                        if (dvalid[c] && dready[c] === 1'b1) sb_q[c].push_back(ddata[c*W +: W]);
                    end
                end
            end
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_checks++; if (dready !== '0) $display("FAIL reset_ready got %b expected 0", dready); else n_pass++;
        n_checks++; if (cvalid !== '0) $display("FAIL reset_valid got %b expected 0", cvalid); else n_pass++;
        n_checks++; if (cdata !== '0) $display("FAIL reset_data got %h expected 0", cdata); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy got %b expected 0", busy); else n_pass++;
        n_checks++; if (done !== 1'b0) $display("FAIL reset_done got %b expected 0", done); else n_pass++;
        step();
        rst = 1'b0;
        step();
        @(negedge clk);
        n_checks++; if (dready !== '0) $display("FAIL post_reset_ready got %b expected 0", dready); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL post_reset_busy got %b expected 0", busy); else n_pass++;
        n_checks++; if (done !== 1'b0) $display("FAIL post_reset_done got %b expected 0", done); else n_pass++;
    endtask

    task automatic test_basic();
        int base_done;
        int base_pop [NC];
        base_done = n_done;
        for (int c = 0; c < NC; c++) base_pop[c] = n_pop[c];
        step();
        dvalid  = '1;
        consume = '1;
        do_start(3);
        @(negedge clk);
        n_checks++; if (dready !== 4'hF) $display("FAIL basic_first_ready got %b expected 1111", dready); else n_pass++;
        n_checks++; if (cvalid !== 4'h0) $display("FAIL basic_valid_early got %b expected 0000", cvalid); else n_pass++;
        n_checks++; if (busy !== 1'b1) $display("FAIL basic_busy got %b expected 1", busy); else n_pass++;
        step();
        @(negedge clk);
        n_checks++; if (cvalid !== 4'hF) $display("FAIL basic_valid_rise got %b expected 1111", cvalid); else n_pass++;
        wait_done(50);
        n_checks++; if (done !== 1'b1) $display("FAIL basic_done_timeout got %b expected 1", done); else n_pass++;
        step();
        dvalid  = '0;
        consume = '0;
        @(negedge clk);
        n_checks++; if (done !== 1'b0) $display("FAIL basic_done_width got %b expected 0", done); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL basic_idle_busy got %b expected 0", busy); else n_pass++;
        n_checks++; if (n_done - base_done !== 1) $display("FAIL basic_done_count got %0d expected 1", n_done - base_done); else n_pass++;
        for (int c = 0; c < NC; c++) begin
            n_checks++;
            if (n_pop[c] - base_pop[c] !== 3) $display("FAIL basic_pops ch%0d got %0d expected 3", c, n_pop[c] - base_pop[c]);
            else n_pass++;
        end
    endtask

    task automatic test_full();
        int base_done;
        int base_pop [NC];
        base_done = n_done;
        for (int c = 0; c < NC; c++) base_pop[c] = n_pop[c];
        step();
        dvalid  = '1;
        consume = '0;
        do_start(8);
        repeat (4) step();
        @(negedge clk);
        n_checks++; if (dready !== 4'h0) $display("FAIL full_ready_low got %b expected 0000", dready); else n_pass++;
        n_checks++; if (cvalid !== 4'hF) $display("FAIL full_valid got %b expected 1111", cvalid); else n_pass++;
        step();
        consume = '1;
        step();
        consume = '0;
        @(negedge clk);
        n_checks++; if (dready !== 4'hF) $display("FAIL full_ready_reraise got %b expected 1111", dready); else n_pass++;
        step();
        @(negedge clk);
        n_checks++; if (dready !== 4'h0) $display("FAIL full_ready_refill got %b expected 0000", dready); else n_pass++;
        step();
        consume = '1;
        wait_done(100);
        n_checks++; if (done !== 1'b1) $display("FAIL full_done_timeout got %b expected 1", done); else n_pass++;
        step();
        dvalid  = '0;
        consume = '0;
        n_checks++; if (n_done - base_done !== 1) $display("FAIL full_done_count got %0d expected 1", n_done - base_done); else n_pass++;
        for (int c = 0; c < NC; c++) begin
            n_checks++;
            if (n_pop[c] - base_pop[c] !== 8) $display("FAIL full_pops ch%0d got %0d expected 8", c, n_pop[c] - base_pop[c]);
            else n_pass++;
        end
    endtask

    task automatic test_zero();
        int base_done;
        base_done = n_done;
        step();
        dvalid = '1;
        start  = 1'b1;
        tsize  = '0;
        @(negedge clk);
        n_checks++; if (done !== 1'b0) $display("FAIL zero_done_early got %b expected 0", done); else n_pass++;
        step();
        start = 1'b0;
        @(negedge clk);
        n_checks++; if (done !== 1'b1) $display("FAIL zero_done got %b expected 1", done); else n_pass++;
        n_checks++; if (dready !== 4'h0) $display("FAIL zero_ready got %b expected 0000", dready); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL zero_busy got %b expected 0", busy); else n_pass++;
        step();
        @(negedge clk);
        n_checks++; if (done !== 1'b0) $display("FAIL zero_done_width got %b expected 0", done); else n_pass++;
        n_checks++; if (dready !== 4'h0) $display("FAIL zero_ready_after got %b expected 0000", dready); else n_pass++;
        step();
        dvalid = '0;
        n_checks++; if (n_done - base_done !== 1) $display("FAIL zero_done_count got %0d expected 1", n_done - base_done); else n_pass++;
    endtask

    task automatic test_stall();
        int base_done;
        int base_pop [NC];
        base_done = n_done;
        for (int c = 0; c < NC; c++) base_pop[c] = n_pop[c];
        step();
        dvalid  = 4'b1011;
        consume = '1;
        do_start(3);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            n_checks++; if (done !== 1'b0) $display("FAIL stall_early_done cycle %0d got %b expected 0", i, done); else n_pass++;
            n_checks++; if (busy !== 1'b1) $display("FAIL stall_busy cycle %0d got %b expected 1", i, busy); else n_pass++;
            step();
        end
        n_checks++; if (n_pop[0] - base_pop[0] !== 3) $display("FAIL stall_ch0_pops got %0d expected 3", n_pop[0] - base_pop[0]); else n_pass++;
        n_checks++; if (n_pop[2] - base_pop[2] !== 0) $display("FAIL stall_ch2_pops got %0d expected 0", n_pop[2] - base_pop[2]); else n_pass++;
        dvalid = '1;
        wait_done(50);
        n_checks++; if (done !== 1'b1) $display("FAIL stall_done_timeout got %b expected 1", done); else n_pass++;
        n_checks++; if (n_pop[2] - base_pop[2] !== 3) $display("FAIL stall_ch2_final got %0d expected 3", n_pop[2] - base_pop[2]); else n_pass++;
        step();
        dvalid  = '0;
        consume = '0;
        n_checks++; if (n_done - base_done !== 1) $display("FAIL stall_done_count got %0d expected 1", n_done - base_done); else n_pass++;
    endtask

    // Abort with two words buffered, via clear_i (use_rst=0) or rst_i (use_rst=1), then restart.
    task automatic test_abort(input bit use_rst);
        int base_done;
        int base_pop [NC];
        base_done = n_done;
        step();
        dvalid  = '1;
        consume = '0;
        do_start(4);
        step();
        step();
        dvalid = '0;
        if (use_rst) begin
            rst = 1'b1;
            #1;
            n_checks++; if (cvalid !== 4'h0) $display("FAIL abort_rst_valid got %b expected 0000", cvalid); else n_pass++;
            step();
            rst = 1'b0;
        end else begin
            clear = 1'b1;
            @(negedge clk);
            n_checks++; if (cvalid !== 4'hF) $display("FAIL abort_buffered got %b expected 1111", cvalid); else n_pass++;
            step();
            clear = 1'b0;
        end
        @(negedge clk);
        n_checks++; if (cvalid !== 4'h0) $display("FAIL abort_valid got %b expected 0000 rst=%0d", cvalid, use_rst); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL abort_busy got %b expected 0 rst=%0d", busy, use_rst); else n_pass++;
        n_checks++; if (dready !== 4'h0) $display("FAIL abort_ready got %b expected 0000 rst=%0d", dready, use_rst); else n_pass++;
        repeat (3) step();
        n_checks++; if (n_done !== base_done) $display("FAIL abort_no_done got %0d expected %0d rst=%0d", n_done, base_done, use_rst); else n_pass++;
        for (int c = 0; c < NC; c++) base_pop[c] = n_pop[c];
        dvalid  = '1;
        consume = '1;
        do_start(2);
        wait_done(50);
        n_checks++; if (done !== 1'b1) $display("FAIL abort_restart_timeout got %b expected 1 rst=%0d", done, use_rst); else n_pass++;
        step();
        dvalid  = '0;
        consume = '0;
        for (int c = 0; c < NC; c++) begin
            n_checks++;
            if (n_pop[c] - base_pop[c] !== 2) $display("FAIL abort_restart_pops ch%0d got %0d expected 2", c, n_pop[c] - base_pop[c]);
            else n_pass++;
        end
    endtask

    task automatic test_restart_ignored();
        int base_pop [NC];
        for (int c = 0; c < NC; c++) base_pop[c] = n_pop[c];
        step();
        dvalid  = '1;
        consume = '0;
        do_start(2);
        step();
        step();
        start = 1'b1;
        tsize = TRANS_W'(5);
        step();
        start = 1'b0;
        @(negedge clk);
        n_checks++; if (dready !== 4'h0) $display("FAIL restart_ready got %b expected 0000", dready); else n_pass++;
        n_checks++; if (cvalid !== 4'hF) $display("FAIL restart_valid got %b expected 1111", cvalid); else n_pass++;
        n_checks++; if (busy !== 1'b1) $display("FAIL restart_busy got %b expected 1", busy); else n_pass++;
        step();
        consume = '1;
        wait_done(50);
        n_checks++; if (done !== 1'b1) $display("FAIL restart_done_timeout got %b expected 1", done); else n_pass++;
        step();
        dvalid  = '0;
        consume = '0;
        @(negedge clk);
        n_checks++; if (busy !== 1'b0) $display("FAIL restart_idle got %b expected 0", busy); else n_pass++;
        for (int c = 0; c < NC; c++) begin
            n_checks++;
            if (n_pop[c] - base_pop[c] !== 2) $display("FAIL restart_pops ch%0d got %0d expected 2", c, n_pop[c] - base_pop[c]);
            else n_pass++;
        end
    endtask

    initial begin
        rst     = 1'b1;
        start   = 1'b0;
        clear   = 1'b0;
        tsize   = '0;
        dvalid  = '0;
        consume = '0;
        ddata   = '0;
        for (int c = 0; c < NC; c++) n_pop[c] = 0;
        fork
            sb_monitor();
        join_none
        test_reset();
        test_basic();
        test_full();
        test_zero();
        test_stall();
        test_abort(1'b0);
        test_abort(1'b1);
        test_restart_ignored();
        step();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", n_pass, n_checks);
        $fatal(1);
    end

endmodule
